csa_accum_sequencer: RTL

Sequential multi-operand adder controller built around the team's 3:2 carry-save compressor. It accepts a start command with an operand count, then streams unsigned operands through a valid/ready handshake. Each operand is folded into a redundant (sum, carry) register pair by one carry-save stage per cycle. A single carry-propagate add at the end produces the binary result, held under a valid/ready handshake. It sits between an operand producer (DMA or FIFO) and any consumer that needs dot-product-style accumulation without a carry chain in the per-operand loop.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_stage.sv | 18 +
 rtl/csa_accum_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save accumulation sequencer.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MAX_OPS = 8;

    // Accumulator width large enough that max_ops full-scale operands never overflow.
    function automatic int acc_width(input int width, input int max_ops);
        return width + $clog2(max_ops);
    endfunction

endpackage

// File: rtl/csa_stage.sv
// Purely combinational 3:2 carry-save compressor, one full adder per bit.
module csa_stage #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] cout
);

    // Bitwise sum and majority carry; carries are not propagated here.
    always_comb begin
        sum  = a ^ b ^ c;
        cout = (a & b) | (a & c) | (b & c);
    end

endmodule

// File: rtl/csa_accum_sequencer.sv
// Multi-operand adder: operands folded into a redundant sum/carry pair one per
// cycle, resolved by a single carry-propagate add before being offered as a result.
module csa_accum_sequencer
    import csa_pkg::*;
#(
    parameter int  WIDTH   = DEF_WIDTH,
    parameter int  MAX_OPS = DEF_MAX_OPS,
    localparam int CNT_W   = $clog2(MAX_OPS + 1),
    localparam int ACC_W   = acc_width(WIDTH, MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1'b1);

    state_t             state_r;
    logic [CNT_W-1:0]   remaining_r;
    logic [ACC_W-1:0]   sum_r;
    logic [ACC_W-1:0]   carry_r;
    logic [ACC_W-1:0]   res_r;
    logic               op_ready_r;
    logic               res_valid_r;
    logic               busy_r;

    logic [CNT_W-1:0]   req_cnt_s;
    logic [ACC_W-1:0]   op_ext_s;
    logic [ACC_W-1:0]   carry_sh_s;
    logic [ACC_W-1:0]   csa_sum_s;
    logic [ACC_W-1:0]   csa_carry_s;

    // Clamp the requested count and align operands/carries to the accumulator width.
    always_comb begin
        if (num_ops > MAX_CNT) begin
            req_cnt_s = MAX_CNT;
        end else begin
            req_cnt_s = num_ops;
        end
        op_ext_s   = ACC_W'(op_data);
        // The bit shifted out is always zero because ACC_W covers the worst-case sum.
        carry_sh_s = carry_r << 1'b1;
    end

    csa_stage #(
        .W (ACC_W)
    ) u_stage (
        .a    (sum_r),
        .b    (carry_sh_s),
        .c    (op_ext_s),
        .sum  (csa_sum_s),
        .cout (csa_carry_s)
    );

    // Job FSM with counter, redundant accumulator, resolve adder and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            remaining_r <= '0;
            sum_r       <= '0;
            carry_r     <= '0;
            res_r       <= '0;
            op_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        remaining_r <= req_cnt_s;
                        sum_r       <= '0;
                        carry_r     <= '0;
                        busy_r      <= 1'b1;
                        if (req_cnt_s != '0) begin
                            state_r    <= ACCUM;
                            op_ready_r <= 1'b1;
                        end else begin
                            state_r    <= RESOLVE;
                        end
                    end
                end
                ACCUM: begin
                    if (op_valid && op_ready_r) begin
                        sum_r       <= csa_sum_s;
                        carry_r     <= csa_carry_s;
                        remaining_r <= remaining_r - ONE_CNT;
                        if (remaining_r == ONE_CNT) begin
                            state_r    <= RESOLVE;
                            op_ready_r <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res_r       <= sum_r + carry_sh_s;
                    res_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    op_ready_r  <= 1'b0;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = op_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_r;
    assign busy      = busy_r;

endmodule
